// File: rtl/quad_pkg.sv
// Shared types and the phase-transition classifier for the quadrature decoder.
// The QUAD_ERR_CNT_EN build also uses ERR_CNT_W for its illegal-transition counter.
package quad_pkg;

   typedef enum logic [1:0] {
      PH_00 = 2'b00,
      PH_10 = 2'b10,
      PH_11 = 2'b11,
      PH_01 = 2'b01
   } phase_t;

   typedef enum logic [1:0] {
      MV_NONE = 2'd0,
      MV_FWD  = 2'd1,
      MV_REV  = 2'd2,
      MV_ILL  = 2'd3
   } mv_t;

   localparam int ERR_CNT_W = 8;

   // Classify one sample-to-sample step of the {a,b} pair.
   // The forward ring is 00 -> 10 -> 11 -> 01 -> 00.
   function automatic mv_t quad_move(input logic [1:0] prev, input logic [1:0] cur);
      phase_t p;
      logic   fwd;
      p   = phase_t'(prev);
      fwd = 1'b0;
      case (p)
         PH_00:   fwd = (cur == PH_10);
         PH_10:   fwd = (cur == PH_11);
         PH_11:   fwd = (cur == PH_01);
         default: fwd = (cur == PH_00);
      endcase
      if (cur == prev)
         return MV_NONE;
      else if ((prev ^ cur) == 2'b11)
         return MV_ILL;
      else if (fwd)
         return MV_FWD;
      else
         return MV_REV;
   endfunction

endpackage

// File: rtl/quad_sync.sv
// Multi-stage synchronizer for one asynchronous phase input.
// Synchronous active-high reset clears every stage.
module quad_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst)
         sync_q <= '0;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with wrapping up/down position, direction, step and err pulses.
// Defining QUAD_ERR_CNT_EN adds err_cnt, a saturating count of illegal transitions.
module quad_decoder
   import quad_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr,
   output logic [WIDTH-1:0] pos,
   output logic             dir,
   output logic             step,
`ifdef QUAD_ERR_CNT_EN
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
`else
   output logic             err
`endif
);

   // prev only holds a synchronized sample one edge after the chain fills,
   // so decode stays off for one edge beyond the synchronizer depth.
   localparam int WARM_EDGES = SYNC_STAGES + 1;

   logic             a_s, b_s;
   logic [1:0]       s, prev_q;
   logic [2:0]       warm_q, warm_d;
   logic [WIDTH-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic             decode_en;
   mv_t              mv;

   quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
      .clk (clk),
      .rst (rst),
      .d_i (a_in),
      .q_o (a_s)
   );

   quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
      .clk (clk),
      .rst (rst),
      .d_i (b_in),
      .q_o (b_s)
   );

   assign s = {a_s, b_s};

   always_comb begin
      decode_en = (warm_q == 3'(WARM_EDGES));
      mv        = decode_en ? quad_move(prev_q, s) : MV_NONE;
      warm_d    = decode_en ? warm_q : warm_q + 3'd1;
      pos_d     = pos_q;
      dir_d     = dir_q;
      step_d    = 1'b0;
      err_d     = 1'b0;
      case (mv)
         MV_FWD: begin
            pos_d  = pos_q + WIDTH'(1);
            dir_d  = 1'b1;
            step_d = 1'b1;
         end
         MV_REV: begin
            pos_d  = pos_q - WIDTH'(1);
            dir_d  = 1'b0;
            step_d = 1'b1;
         end
         MV_ILL:  err_d = 1'b1;
         default: ;
      endcase
      // clr wins over the count but not over step/dir/err.
      if (clr)
         pos_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= 2'b00;
         warm_q <= 3'd0;
         pos_q  <= '0;
         dir_q  <= 1'b1;
         step_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         prev_q <= s;
         warm_q <= warm_d;
         pos_q  <= pos_d;
         dir_q  <= dir_d;
         step_q <= step_d;
         err_q  <= err_d;
      end
   end

   assign pos  = pos_q;
   assign dir  = dir_q;
   assign step = step_q;
   assign err  = err_q;

`ifdef QUAD_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((mv == MV_ILL) && (err_cnt_q != '1))
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      if (clr)
         err_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst)
         err_cnt_q <= '0;
      else
         err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: stimulus tasks push expected pulses into a queue,
// a negedge monitor pops and compares each step/err pulse including its arrival cycle.
module tb_quad_decoder;

   localparam int WIDTH = 8;
   localparam int SS    = 2;
   localparam int HOLD  = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             a_in = 1'b0;
   logic             b_in = 1'b0;
   logic             clr = 1'b0;
   logic [WIDTH-1:0] pos;
   logic             dir, step, err;
`ifdef QUAD_ERR_CNT_EN
   logic [7:0]       err_cnt;
`endif

   quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
      .clk     (clk),
      .rst     (rst),
      .a_in    (a_in),
      .b_in    (b_in),
      .clr     (clr),
      .pos     (pos),
      .dir     (dir),
      .step    (step),
`ifdef QUAD_ERR_CNT_EN
      .err     (err),
      .err_cnt (err_cnt)
`else
      .err     (err)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses   = 0;

   // entry: [25]=err, [24]=dir, [23:16]=pos, [15:0]=cycle the pulse is due
   logic [25:0] exp_q[$];
   logic [25:0] mon_e;

   logic [1:0]       ph_m;
   logic [WIDTH-1:0] pos_m;
   logic             dir_m;
   logic [1:0]       fwd_seq[4] = '{2'b10, 2'b11, 2'b01, 2'b00};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   function automatic int ring_idx(input logic [1:0] p);
      case (p)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act == req)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d (cyc=%0d)", name, act, req, cyc);
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (step || err) begin
         pulses++;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse: cyc=%0d step=%0b err=%0b pos=%0d", cyc, step, err, pos);
         end else begin
            mon_e = exp_q.pop_front();
            if ({err, step, dir, pos, cyc[15:0]} ==
                {mon_e[25], ~mon_e[25], mon_e[24], mon_e[23:16], mon_e[15:0]})
               n_pass++;
            else
               $display("FAIL pulse_cmp: got err=%0b step=%0b dir=%0b pos=%0d cyc=%0d, expected err=%0b step=%0b dir=%0b pos=%0d cyc=%0d",
                        err, step, dir, pos, cyc[15:0],
                        mon_e[25], ~mon_e[25], mon_e[24], mon_e[23:16], mon_e[15:0]);
         end
      end else if (exp_q.size() != 0 && exp_q[0][15:0] < cyc[15:0]) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         $display("FAIL missing_pulse: got none by cyc=%0d, expected err=%0b pos=%0d at cyc=%0d",
                  cyc, mon_e[25], mon_e[23:16], mon_e[15:0]);
      end
   end

   // driver tasks
   task automatic do_reset(input logic [1:0] ph, input int n);
      @(negedge clk);
      rst = 1'b1;
      {a_in, b_in} = ph;
      repeat (n) @(negedge clk);
      check("rst_pos", pos, 0);
      check("rst_dir", dir, 1);
      check("rst_step", step, 0);
      check("rst_err", err, 0);
      rst   = 1'b0;
      ph_m  = ph;
      pos_m = '0;
      dir_m = 1'b1;
   endtask

   task automatic move(input logic [1:0] ph, input int hold);
      int d;
      @(negedge clk);
      {a_in, b_in} = ph;
      d = (ring_idx(ph) - ring_idx(ph_m) + 4) % 4;
      if (d == 1) begin
         pos_m++;
         dir_m = 1'b1;
      end else if (d == 3) begin
         pos_m--;
         dir_m = 1'b0;
      end
      if (d != 0)
         exp_q.push_back({d == 2, dir_m, pos_m, 16'(cyc + 1 + SS)});
      ph_m = ph;
      repeat (hold - 1) @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr   = 1'b0;
      pos_m = '0;
   endtask

   int p0;

   initial begin
      // reset with both phases high, then idle
      do_reset(2'b11, 3);
      repeat (10) @(negedge clk);
      check("idle_pos", pos, 0);
      check("idle_dir", dir, 1);
      check("idle_no_pulse", pulses, 0);

      // 8 full forward cycles
      do_reset(2'b00, 2);
      p0 = pulses;
      for (int i = 0; i < 32; i++) move(fwd_seq[i % 4], HOLD);
      repeat (SS + 2) @(negedge clk);
      check("fwd_pos", pos, 32);
      check("fwd_dir", dir, 1);
      check("fwd_steps", pulses - p0, 32);

      pulse_clr();
      check("clr_idle_pos", pos, 0);

      // clr collides with a decoded forward step at pos=5
      for (int i = 0; i < 5; i++) move(fwd_seq[i % 4], HOLD);
      @(negedge clk);
      check("pre_clr_pos", pos, 5);
      @(negedge clk);
      {a_in, b_in} = 2'b11;
      pos_m = '0;
      dir_m = 1'b1;
      exp_q.push_back({1'b0, 1'b1, 8'd0, 16'(cyc + 1 + SS)});
      ph_m = 2'b11;
      repeat (SS) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_collision_pos", pos, 0);
      check("clr_collision_dir", dir, 1);

      // reverse wrap from 0
      move(2'b01, HOLD);
      move(2'b00, HOLD);
      pulse_clr();
      move(2'b01, HOLD);
      move(2'b11, HOLD);
      move(2'b10, HOLD);
      @(negedge clk);
      check("rev_wrap_pos", pos, 253);
      check("rev_wrap_dir", dir, 0);

      // illegal double-phase changes
      move(2'b00, HOLD);
      move(2'b11, HOLD);
      @(negedge clk);
      check("ill_pos_hold", pos, 252);
      check("ill_dir_hold", dir, 0);
      move(2'b00, HOLD);
      move(2'b11, HOLD);
      move(2'b00, HOLD);
`ifdef QUAD_ERR_CNT_EN
      @(negedge clk);
      check("err_cnt_4", err_cnt, 4);
      for (int i = 0; i < 300; i++) move(ph_m ^ 2'b11, 2);
      repeat (SS + 2) @(negedge clk);
      check("err_cnt_sat", err_cnt, 255);
      pulse_clr();
      check("err_cnt_clr", err_cnt, 0);
`endif

      // reset in the middle of forward motion
      do_reset(2'b00, 2);
      for (int i = 0; i < 17; i++) move(fwd_seq[i % 4], HOLD);
      @(negedge clk);
      check("pre_rst_pos", pos, 17);
      {a_in, b_in} = 2'b11;
      ph_m = 2'b11;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_pos", pos, 0);
      check("midrst_dir", dir, 1);
      check("midrst_step", step, 0);
      rst   = 1'b0;
      pos_m = '0;
      dir_m = 1'b1;
      p0    = pulses;
      repeat (SS + 2) @(negedge clk);
      check("warmup_no_pulse", pulses - p0, 0);
      move(2'b01, HOLD);
      @(negedge clk);
      check("post_rst_pos", pos, 1);

      repeat (5) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
